// File: rtl/cordic_engine.sv
// cordic_engine: iterative CORDIC core, one micro-rotation per clock.
//   mode 0 (rotation):  drives z toward 0; x_out/y_out = cos/sin scaled by |(x,y)|.
//   mode 1 (vectoring): drives y toward 0; x_out = magnitude, z_out = z_in + atan2(y,x).
// Full-circle range comes from a quadrant pre-rotation (PRE) before the
// iterations; optional 1/K gain compensation and saturation happen in POST.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, mode         request (sampled only in IDLE) and operation select
//   x_in, y_in          signed Q2.(WIDTH-2), latched with start
//   z_in                signed Q3.(WIDTH-3) radians, latched with start
//   busy                high while PRE/ITER/POST are running
//   done                one-cycle pulse, x_out/y_out/z_out valid and held
module cordic_engine #(
    parameter int WIDTH     = 16,
    parameter int ITERS     = 14,
    parameter int GAIN_COMP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);

    localparam int IW   = WIDTH + 2;          // x/y guard for gain * sqrt(2)
    localparam int FRAC = WIDTH - 3;          // fractional bits of z
    localparam int CW   = $clog2(ITERS);
    localparam int PW   = IW + WIDTH + 1;     // gain-compensation product width

    // Angles are kept as Q.30 integers and rounded to nearest into z format.
    function automatic longint q30_to_z(input longint v);
        return (v + (longint'(1) <<< (29 - FRAC))) >>> (30 - FRAC);
    endfunction

    // atan(2^-i) * 2^30; beyond i=7 the series 2^-i - 2^-3i/3 is exact
    // to well under one Q.30 LSB.
    function automatic longint atan_q30(input int i);
        longint v;
        case (i)
            0:       v = 64'sd843314857;
            1:       v = 64'sd497837829;
            2:       v = 64'sd263043837;
            3:       v = 64'sd133525159;
            4:       v = 64'sd67021687;
            5:       v = 64'sd33543516;
            6:       v = 64'sd16775851;
            7:       v = 64'sd8388437;
            default: begin
                v = longint'(1) <<< (30 - i);
                if (i <= 10) v = v - ((longint'(1) <<< (30 - 3 * i)) / 3);
            end
        endcase
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if ((&v[PW-1:WIDTH-1]) || !(|v[PW-1:WIDTH-1])) return v[WIDTH-1:0];
        return v[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(q30_to_z(64'sd1686629713));
    // round(2^(WIDTH-2) / 1.646760) in integer arithmetic
    localparam longint GAIN_L =
        ((longint'(1) <<< (WIDTH - 2)) * 1000000 + 823380) / 1646760;
    localparam logic signed [WIDTH:0] GAIN_C = (WIDTH+1)'(GAIN_L);

    typedef enum logic [1:0] {IDLE, PRE, ITER, POST} state_t;

    state_t                  state, state_nxt;
    logic signed [IW-1:0]    xr, yr;
    logic signed [WIDTH-1:0] zr;
    logic                    mode_r;
    logic [CW-1:0]           cnt;

    logic signed [WIDTH-1:0] atan_tab [ITERS];
    for (genvar g = 0; g < ITERS; g++) begin : g_atan
        assign atan_tab[g] = WIDTH'(q30_to_z(atan_q30(g)));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PRE;
            PRE:     state_nxt = ITER;
            ITER:    if (cnt == CW'(ITERS - 1)) state_nxt = POST;
            POST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------- quadrant pre-rotation ----------------
    logic signed [IW-1:0]    x_pre, y_pre;
    logic signed [WIDTH-1:0] z_pre;

    always_comb begin
        x_pre = xr;
        y_pre = yr;
        z_pre = zr;
        if (!mode_r) begin
            if (zr > HALF_PI) begin
                x_pre = -yr; y_pre = xr;  z_pre = zr - HALF_PI;
            end else if (zr < -HALF_PI) begin
                x_pre = yr;  y_pre = -xr; z_pre = zr + HALF_PI;
            end
        end else if (xr[IW-1]) begin
            // left half-plane: rotate into the right half, account in z
            if (!yr[IW-1]) begin
                x_pre = yr;  y_pre = -xr; z_pre = zr + HALF_PI;
            end else begin
                x_pre = -yr; y_pre = xr;  z_pre = zr - HALF_PI;
            end
        end
    end

    // ---------------- micro-rotation ----------------
    logic                    d_pos;
    logic signed [IW-1:0]    x_sh, y_sh, x_it, y_it;
    logic signed [WIDTH-1:0] z_it;

    always_comb begin
        d_pos = mode_r ? yr[IW-1] : ~zr[WIDTH-1];
        x_sh  = xr >>> cnt;
        y_sh  = yr >>> cnt;
        x_it  = d_pos ? xr - y_sh : xr + y_sh;
        y_it  = d_pos ? yr + x_sh : yr - x_sh;
        z_it  = d_pos ? zr - atan_tab[cnt] : zr + atan_tab[cnt];
    end

    // ---------------- gain compensation ----------------
    logic signed [PW-1:0] x_prod, y_prod, x_scl, y_scl;

    always_comb begin
        x_prod = PW'(xr) * PW'(GAIN_C);
        y_prod = PW'(yr) * PW'(GAIN_C);
        if (GAIN_COMP != 0) begin
            x_scl = x_prod >>> (WIDTH - 2);
            y_scl = y_prod >>> (WIDTH - 2);
        end else begin
            x_scl = PW'(xr);
            y_scl = PW'(yr);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr     <= '0;
            yr     <= '0;
            zr     <= '0;
            mode_r <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    xr     <= IW'($signed(x_in));
                    yr     <= IW'($signed(y_in));
                    zr     <= $signed(z_in);
                    mode_r <= mode;
                    cnt    <= '0;
                end
                PRE: begin
                    xr <= x_pre;
                    yr <= y_pre;
                    zr <= z_pre;
                end
                ITER: begin
                    xr  <= x_it;
                    yr  <= y_it;
                    zr  <= z_it;
                    cnt <= cnt + 1'b1;
                end
                POST: begin
                    x_out <= sat(x_scl);
                    y_out <= sat(y_scl);
                    z_out <= zr;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
